lector_teclado: RTL and testbench

LECTOR_TECLADO -- requirements
Module: lector_teclado

---
 rtl/lector_pkg.sv | 30 +++
 rtl/lector_teclado_sincronizador.sv | 26 ++
 rtl/lector_teclado.sv | 137 +++++++++++++
 tb/tb_lector_teclado.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lector_pkg.sv
// Shared types and helpers for the keypad reader: FSM states, key code type,
// keypad geometry and one-hot utilities.
package lector_pkg;

  localparam int N_FIL = 4;
  localparam int N_COL = 4;

  typedef enum logic [1:0] {
    REPOSO,
    FILTRO,
    PRESIONADA
  } estado_t;

  typedef logic [3:0] tecla_t;

  function automatic logic es_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Position of the set bit in a one-hot vector; only called on one-hot inputs.
  function automatic logic [1:0] indice(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lector_teclado_sincronizador.sv
// Two-flop synchronizer bringing an asynchronous bus into the clk domain.
module sincronizador #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lector_teclado.sv
// Debounced 4x4 keypad reader. Optional auto-repeat of the held key is
// enabled by defining LECTOR_REPETIR_EN.
module lector_teclado
  import lector_pkg::*;
#(
  parameter int N_DEB = 16,
  parameter int N_REP = 50000
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic [N_COL-1:0] col,
  input  logic [N_FIL-1:0] fil,
  output tecla_t tecla,
  output logic   tecla_valida,
  output logic   tecla_activa
);

  localparam int CW = $clog2(N_DEB + 1);
  localparam logic [CW-1:0] CNT_FIN = CW'(N_DEB);

  if (N_DEB < 1 || N_REP < 1) begin : g_param_err
    $error("lector_teclado: N_DEB and N_REP must be at least 1");
  end

  logic [N_FIL-1:0] fil_s;
  logic [N_COL-1:0] col_d1_q;
  logic [N_COL-1:0] col_al_q;
  estado_t          estado_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_inc_d;
  logic [N_COL-1:0] col_cap_q;
  logic [N_FIL-1:0] fil_cap_q;
  tecla_t           tecla_q;
  logic             valida_q;
  logic             muestra_ok;
  logic             misma_col;

  sincronizador #(.W(N_FIL)) u_sync_fil (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (fil),
    .q_o   (fil_s)
  );

  // col passes through the same two-stage depth as fil so each row sample
  // lines up with the column that was driving when it was taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_d1_q <= '0;
      col_al_q <= '0;
    end else begin
      col_d1_q <= col;
      col_al_q <= col_d1_q;
    end
  end

  assign muestra_ok = es_onehot(col_al_q);
  assign misma_col  = muestra_ok && (col_al_q == col_cap_q);
  assign cnt_inc_d  = (cnt_q == CNT_FIN) ? cnt_q : cnt_q + CW'(1);

`ifdef LECTOR_REPETIR_EN
  localparam int RW = (N_REP > 1) ? $clog2(N_REP) : 1;
  localparam logic [RW-1:0] REP_FIN = RW'(N_REP - 1);
  logic [RW-1:0] rep_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= REPOSO;
      cnt_q     <= '0;
      col_cap_q <= '0;
      fil_cap_q <= '0;
      tecla_q   <= '0;
      valida_q  <= 1'b0;
`ifdef LECTOR_REPETIR_EN
      rep_q     <= '0;
`endif
    end else begin
      valida_q <= 1'b0;
      case (estado_q)
        REPOSO: begin
          if (muestra_ok && es_onehot(fil_s)) begin
            col_cap_q <= col_al_q;
            fil_cap_q <= fil_s;
            cnt_q     <= CW'(1);
            estado_q  <= FILTRO;
          end
        end
        FILTRO: begin
          if (cnt_q == CNT_FIN) begin
            tecla_q  <= {indice(fil_cap_q), indice(col_cap_q)};
            valida_q <= 1'b1;
            cnt_q    <= '0;
            estado_q <= PRESIONADA;
`ifdef LECTOR_REPETIR_EN
            rep_q    <= '0;
`endif
          end else if (misma_col) begin
            if (fil_s == fil_cap_q) begin
              cnt_q <= cnt_inc_d;
            end else begin
              cnt_q    <= '0;
              estado_q <= REPOSO;
            end
          end
        end
        PRESIONADA: begin
          // Release needs N_DEB consecutive low samples of the captured row.
          if (cnt_q == CNT_FIN) begin
            cnt_q    <= '0;
            estado_q <= REPOSO;
          end else if (misma_col) begin
            if ((fil_s & fil_cap_q) == '0) cnt_q <= cnt_inc_d;
            else                           cnt_q <= '0;
          end
`ifdef LECTOR_REPETIR_EN
          if (rep_q == REP_FIN) begin
            rep_q    <= '0;
            valida_q <= 1'b1;
          end else begin
            rep_q <= rep_q + RW'(1);
          end
`endif
        end
        default: begin
          cnt_q    <= '0;
          estado_q <= REPOSO;
        end
      endcase
    end
  end

  assign tecla        = tecla_q;
  assign tecla_valida = valida_q;
  assign tecla_activa = (estado_q == PRESIONADA);

endmodule

// File: tb/tb_lector_teclado.sv
// Self-checking bench for lector_teclado: rotating column scanner, keypad
// model, pulse scoreboard, table-driven key sequences and multi-cycle corners.
module tb_lector_teclado;

  localparam int N_DEB = 4;
  localparam int N_REP = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col = 4'b0001;
  logic [3:0] fil;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       tecla_activa;

  logic [15:0] keymask = '0;
  logic        fil_force = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_pulses = 0;
  int last_pulse_cyc = 0;
  logic [3:0] exp_q[$];
  int         rep_q[$];
  logic [3:0] rep_tecla_exp = '0;
  logic       prev_activa = 1'b0;

  typedef struct {
    logic [15:0] keys;
    int          hold;
    int          pulses;
    logic [3:0]  tecla;
    logic        activa;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  lector_teclado #(.N_DEB(N_DEB), .N_REP(N_REP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .col          (col),
    .fil          (fil),
    .tecla        (tecla),
    .tecla_valida (tecla_valida),
    .tecla_activa (tecla_activa)
  );

  // Key k sits at row k/4, column k%4, so its expected code is simply k.
  always_comb begin
    fil = '0;
    for (int r = 0; r < 4; r++) fil[r] = |(keymask[r*4 +: 4] & col);
    if (fil_force) fil = 4'hF;
  end

  always @(negedge clk) col = {col[2:0], col[3]};

  task automatic checkOutput(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    cyc++;
    if (tecla_valida === 1'b1) begin
      n_pulses++;
      last_pulse_cyc = cyc;
`ifdef LECTOR_REPETIR_EN
      if (prev_activa) begin
        rep_q.push_back(cyc);
        checkOutput("repeat tecla", int'(tecla), int'(rep_tecla_exp));
      end else
`endif
      if (exp_q.size() == 0) begin
        checkOutput("unexpected pulse", int'(tecla_valida), 0);
      end else begin
        e = exp_q.pop_front();
        rep_tecla_exp = e;
        checkOutput("pulse tecla", int'(tecla), int'(e));
      end
    end
    prev_activa = tecla_activa;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic syncCol();
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (col == 4'b0010) break;
    end
  endtask

  task automatic waitPulse(input int budget, output int got);
    int start;
    start = n_pulses;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (n_pulses != start) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    for (int i = 0; i < v.pulses; i++) exp_q.push_back(v.tecla);
    keymask = v.keys;
    step(v.hold);
    checkOutput($sformatf("vec%0d pending pulses", idx), exp_q.size(), 0);
    checkOutput($sformatf("vec%0d tecla_activa", idx), int'(tecla_activa), int'(v.activa));
    checkOutput($sformatf("vec%0d tecla", idx), int'(tecla), int'(v.tecla));
  endtask

  initial begin
    int got;
    int t0;
    int n;

    vecs[0] = '{keys: 16'h0208, hold: 30, pulses: 0, tecla: 4'd9,  activa: 1'b1};
    vecs[1] = '{keys: 16'h0000, hold: 30, pulses: 0, tecla: 4'd9,  activa: 1'b0};
    vecs[2] = '{keys: 16'h0040, hold: 30, pulses: 1, tecla: 4'd6,  activa: 1'b1};
    vecs[3] = '{keys: 16'h0000, hold: 30, pulses: 0, tecla: 4'd6,  activa: 1'b0};
    vecs[4] = '{keys: 16'h0220, hold: 30, pulses: 0, tecla: 4'd6,  activa: 1'b0};
    vecs[5] = '{keys: 16'h0000, hold: 10, pulses: 0, tecla: 4'd6,  activa: 1'b0};
    vecs[6] = '{keys: 16'h8000, hold: 30, pulses: 1, tecla: 4'd15, activa: 1'b1};
    vecs[7] = '{keys: 16'h0000, hold: 30, pulses: 0, tecla: 4'd15, activa: 1'b0};
    vecs[8] = '{keys: 16'h0001, hold: 30, pulses: 1, tecla: 4'd0,  activa: 1'b1};
    vecs[9] = '{keys: 16'h0000, hold: 30, pulses: 0, tecla: 4'd0,  activa: 1'b0};

    rst_n = 1'b0;
    fil_force = 1'b1;
    step(10);
    checkOutput("reset tecla", int'(tecla), 0);
    checkOutput("reset tecla_valida", int'(tecla_valida), 0);
    checkOutput("reset tecla_activa", int'(tecla_activa), 0);
    fil_force = 1'b0;
    rst_n = 1'b1;
    step(12);
    checkOutput("idle tecla_activa", int'(tecla_activa), 0);
    checkOutput("idle pulses", n_pulses, 0);

    // Bounce: two matching samples of key 9, then released.
    syncCol();
    keymask = 16'h0200;
    step(5);
    keymask = '0;
    step(20);
    checkOutput("bounce tecla_activa", int'(tecla_activa), 0);
    checkOutput("bounce pulses", n_pulses, 0);

    // Reset in the middle of filtering discards the key.
    syncCol();
    keymask = 16'h0200;
    step(8);
    rst_n = 1'b0;
    keymask = '0;
    step(3);
    checkOutput("midrst tecla", int'(tecla), 0);
    checkOutput("midrst tecla_activa", int'(tecla_activa), 0);
    rst_n = 1'b1;
    step(30);
    checkOutput("midrst pulses", n_pulses, 0);
    checkOutput("midrst tecla after", int'(tecla), 0);
    checkOutput("midrst activa after", int'(tecla_activa), 0);

    // Clean press of key 9 with exact latency from the first driven phase.
    exp_q.push_back(4'd9);
    syncCol();
    keymask = 16'h0200;
    t0 = cyc;
    waitPulse(40, got);
    checkOutput("press pulse seen", got, 1);
    checkOutput("press latency", last_pulse_cyc - t0, 4 * N_DEB);
    checkOutput("press tecla", int'(tecla), 9);
    checkOutput("press tecla_activa", int'(tecla_activa), 1);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

`ifdef LECTOR_REPETIR_EN
    exp_q.push_back(4'd9);
    keymask = 16'h0200;
    waitPulse(40, got);
    checkOutput("repeat base pulse", got, 1);
    t0 = last_pulse_cyc;
    rep_q.delete();
    step(65);
    checkOutput("repeat count", rep_q.size(), 3);
    n = (rep_q.size() < 3) ? rep_q.size() : 3;
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("repeat %0d offset", i), rep_q[i] - t0, N_REP * (i + 1));
    keymask = '0;
    step(40);
    checkOutput("repeat release activa", int'(tecla_activa), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
